layer1: RTL and testbench

LAYER1 -- requirements
Module: layer1

---
 rtl/layer1.sv | 126 ++++++++++++
 tb/tb_layer1.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer1.sv
// Approximate 16-row to 8-row partial-product reducer, per-column, no inter-column carries.
// Latency: 1 cycle, all outputs registered; inputs are sampled directly.
// Backpressure: none, a new matrix is accepted on every clock.
module layer1 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a1,
    input  logic [15:0] a2,
    input  logic [15:0] a3,
    input  logic [15:0] a4,
    input  logic [15:0] a5,
    input  logic [15:0] a6,
    input  logic [15:0] a7,
    input  logic [15:0] a8,
    input  logic [15:0] a9,
    input  logic [15:0] a10,
    input  logic [15:0] a11,
    input  logic [15:0] a12,
    input  logic [15:0] a13,
    input  logic [15:0] a14,
    input  logic [15:0] a15,
    input  logic [15:0] a16,
    output logic [31:1] b1,
    output logic [30:2] b2,
    output logic [29:3] b3,
    output logic [28:4] b4,
    output logic [27:5] b5,
    output logic [26:6] b6,
    output logic [25:7] b7,
    output logic [25:8] b8,
    output logic        err1,
    output logic        err2
);

    // Row i, local bit k sits at flat[(i-1)*16 + k] and carries weight i+k.
    logic [255:0] flat;
    assign flat = {a16, a15, a14, a13, a12, a11, a10, a9,
                   a8,  a7,  a6,  a5,  a4,  a3,  a2,  a1};

    // slots[j][s] is the bit that lands in output row s+1 at weight j.
    logic [7:0]  slots [1:31];
    logic        err_lo;
    logic        err_hi;
    int          lo;
    int          h;
    int          e;
    logic [15:0] xv;
    logic [7:0]  sl;
    logic        pe;

    // Per-column reduction: gather the column, OR-pair the surplus bits, pass the rest.
    // Columns whose height is 8 or less (including 24 and 25, which hold only 8 and 7
    // bits) pass straight through; slots with no source bit read as 0, so b8[25] is 0.
    always_comb begin
        err_lo = 1'b0;
        err_hi = 1'b0;
        lo     = 1;
        h      = 0;
        e      = 0;
        xv     = '0;
        sl     = '0;
        pe     = 1'b0;
        for (int j = 1; j <= 31; j++) begin
            slots[5'(j)] = '0;
        end
        for (int j = 1; j <= 31; j++) begin
            lo = (j > 16) ? j - 15 : 1;
            h  = (j > 16) ? 32 - j : j;
            e  = h - 8;
            xv = '0;
            sl = '0;
            pe = 1'b0;
            for (int t = 0; t < 16; t++) begin
                if (t < h) begin
                    xv[4'(t)] = flat[8'(15 * (lo + t) + j - 16)];
                end
            end
            for (int s = 0; s < 8; s++) begin
                if (h <= 8) begin
                    if (s < h) begin
                        sl[3'(s)] = xv[4'(s)];
                    end
                end else if (s < e) begin
                    sl[3'(s)] = xv[4'(2 * s)] | xv[4'(2 * s + 1)];
                    pe        = pe | (xv[4'(2 * s)] & xv[4'(2 * s + 1)]);
                end else begin
                    sl[3'(s)] = xv[4'(s + e)];
                end
            end
            slots[5'(j)] = sl;
            if (j <= 16) begin
                err_lo = err_lo | pe;
            end else begin
                err_hi = err_hi | pe;
            end
        end
    end

    // Output registers: clear on reset, otherwise scatter each slot into its row.
    always_ff @(posedge clk) begin
        if (rst) begin
            b1   <= '0;
            b2   <= '0;
            b3   <= '0;
            b4   <= '0;
            b5   <= '0;
            b6   <= '0;
            b7   <= '0;
            b8   <= '0;
            err1 <= 1'b0;
            err2 <= 1'b0;
        end else begin
            for (int j = 1; j <= 31; j++) b1[5'(j)] <= slots[5'(j)][0];
            for (int j = 2; j <= 30; j++) b2[5'(j)] <= slots[5'(j)][1];
            for (int j = 3; j <= 29; j++) b3[5'(j)] <= slots[5'(j)][2];
            for (int j = 4; j <= 28; j++) b4[5'(j)] <= slots[5'(j)][3];
            for (int j = 5; j <= 27; j++) b5[5'(j)] <= slots[5'(j)][4];
            for (int j = 6; j <= 26; j++) b6[5'(j)] <= slots[5'(j)][5];
            for (int j = 7; j <= 25; j++) b7[5'(j)] <= slots[5'(j)][6];
            for (int j = 8; j <= 25; j++) b8[5'(j)] <= slots[5'(j)][7];
            err1 <= err_lo;
            err2 <= err_hi;
        end
    end

endmodule

// File: tb/tb_layer1.sv
// Directed bench for layer1: reset, all-ones, alternating, single-bit column placements,
// pair errors at column boundaries, latency and mid-run reset.
// Inputs driven 1ns after the rising edge, outputs sampled 1ns after the next one.
module tb_layer1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] av [1:16];
    logic [31:1] b1;
    logic [30:2] b2;
    logic [29:3] b3;
    logic [28:4] b4;
    logic [27:5] b5;
    logic [26:6] b6;
    logic [25:7] b7;
    logic [25:8] b8;
    logic        err1;
    logic        err2;

    logic [31:1] x_b1;
    logic [30:2] x_b2;
    logic [29:3] x_b3;
    logic [28:4] x_b4;
    logic [27:5] x_b5;
    logic [26:6] x_b6;
    logic [25:7] x_b7;
    logic [25:8] x_b8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          ra;
        logic [15:0] va;
        int          rb;
        logic [15:0] vb;
        int          k;
        int          w;
        logic        e1;
        logic        e2;
    } vec_t;

    vec_t vecs [17];

    always #5 clk = ~clk;

    layer1 dut (
        .clk(clk), .rst(rst),
        .a1(av[1]),   .a2(av[2]),   .a3(av[3]),   .a4(av[4]),
        .a5(av[5]),   .a6(av[6]),   .a7(av[7]),   .a8(av[8]),
        .a9(av[9]),   .a10(av[10]), .a11(av[11]), .a12(av[12]),
        .a13(av[13]), .a14(av[14]), .a15(av[15]), .a16(av[16]),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7), .b8(b8),
        .err1(err1), .err2(err2)
    );

    task automatic set_all(input logic [15:0] v);
        for (int i = 1; i <= 16; i++) av[i] = v;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp;
        x_b1 = '0; x_b2 = '0; x_b3 = '0; x_b4 = '0;
        x_b5 = '0; x_b6 = '0; x_b7 = '0; x_b8 = '0;
    endtask

    task automatic set_vec(input int n, input int ra, input logic [15:0] va, input int rb,
                           input logic [15:0] vb, input int k, input int w,
                           input logic e1, input logic e2);
        vecs[n].ra = ra; vecs[n].va = va; vecs[n].rb = rb; vecs[n].vb = vb;
        vecs[n].k  = k;  vecs[n].w  = w;  vecs[n].e1 = e1; vecs[n].e2 = e2;
    endtask

    task automatic init_vecs;
        set_vec(0,  16, 16'h0001, 0,  16'h0000, 8, 16, 1'b0, 1'b0);
        set_vec(1,  1,  16'h8000, 2,  16'h4000, 1, 16, 1'b1, 1'b0);
        set_vec(2,  1,  16'h0001, 0,  16'h0000, 1, 1,  1'b0, 1'b0);
        set_vec(3,  16, 16'h8000, 0,  16'h0000, 1, 31, 1'b0, 1'b0);
        set_vec(4,  8,  16'h0001, 0,  16'h0000, 8, 8,  1'b0, 1'b0);
        set_vec(5,  9,  16'h0001, 0,  16'h0000, 8, 9,  1'b0, 1'b0);
        set_vec(6,  1,  16'h0100, 2,  16'h0080, 1, 9,  1'b1, 1'b0);
        set_vec(7,  9,  16'h0080, 0,  16'h0000, 5, 16, 1'b0, 1'b0);
        set_vec(8,  15, 16'h0002, 16, 16'h0001, 8, 16, 1'b1, 1'b0);
        set_vec(9,  2,  16'h8000, 3,  16'h4000, 1, 17, 1'b0, 1'b1);
        set_vec(10, 8,  16'h8000, 9,  16'h4000, 1, 23, 1'b0, 1'b1);
        set_vec(11, 16, 16'h0080, 0,  16'h0000, 8, 23, 1'b0, 1'b0);
        set_vec(12, 16, 16'h0100, 0,  16'h0000, 8, 24, 1'b0, 1'b0);
        set_vec(13, 10, 16'h8000, 0,  16'h0000, 1, 25, 1'b0, 1'b0);
        set_vec(14, 16, 16'h0200, 0,  16'h0000, 7, 25, 1'b0, 1'b0);
        set_vec(15, 16, 16'h0002, 0,  16'h0000, 8, 17, 1'b0, 1'b0);
        set_vec(16, 3,  16'h0080, 0,  16'h0000, 2, 10, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        set_all(16'hFFFF);
        tick;
        checks++;
        if ({b1, b2, b3, b4, b5, b6, b7, b8} !== 193'd0) begin
            failures++;
            $display("FAIL reset_rows got=%h want=0", {b1, b2, b3, b4, b5, b6, b7, b8});
        end
        checks++;
        if ({err1, err2} !== 2'b00) begin
            failures++;
            $display("FAIL reset_err got=%b%b want=00", err1, err2);
        end
    endtask

    task automatic test_all_ones(input string name);
        set_all(16'hFFFF);
        tick;
        x_b1 = '1; x_b2 = '1; x_b3 = '1; x_b4 = '1;
        x_b5 = '1; x_b6 = '1; x_b7 = '1; x_b8 = '1;
        // Column 25 holds only seven bits, so row 8 has no source there.
        x_b8[25] = 1'b0;
        checks++;
        if ({b1, b2, b3, b4, b5, b6, b7, b8} !== {x_b1, x_b2, x_b3, x_b4, x_b5, x_b6, x_b7, x_b8}) begin
            failures++;
            $display("FAIL %s_rows got=%h want=%h", name, {b1, b2, b3, b4, b5, b6, b7, b8},
                     {x_b1, x_b2, x_b3, x_b4, x_b5, x_b6, x_b7, x_b8});
        end
        checks++;
        if ({err1, err2} !== 2'b11) begin
            failures++;
            $display("FAIL %s_err got=%b%b want=11", name, err1, err2);
        end
    endtask

    task automatic test_mid_reset;
        rst = 1'b1;
        tick;
        checks++;
        if ({b1, b2, b3, b4, b5, b6, b7, b8, err1, err2} !== 195'd0) begin
            failures++;
            $display("FAIL mid_reset got=%h want=0", {b1, b2, b3, b4, b5, b6, b7, b8, err1, err2});
        end
        rst = 1'b0;
    endtask

    task automatic test_alternating;
        longint in_sum;
        longint out_sum;
        set_all(16'hAAAA);
        tick;
        in_sum = 0;
        for (int i = 1; i <= 16; i++) in_sum += longint'(av[i]) << (i - 1);
        out_sum = longint'(b1) + (longint'(b2) << 1) + (longint'(b3) << 2) + (longint'(b4) << 3)
                + (longint'(b5) << 4) + (longint'(b6) << 5) + (longint'(b7) << 6) + (longint'(b8) << 7);
        checks++;
        if ({err1, err2} !== 2'b00) begin
            failures++;
            $display("FAIL alt_err got=%b%b want=00", err1, err2);
        end
        checks++;
        if (out_sum !== in_sum) begin
            failures++;
            $display("FAIL alt_sum got=%0d want=%0d", out_sum, in_sum);
        end
    endtask

    task automatic test_single_bits;
        for (int n = 0; n < 17; n++) begin
            set_all(16'h0000);
            av[vecs[n].ra] = vecs[n].va;
            if (vecs[n].rb != 0) av[vecs[n].rb] = vecs[n].vb;
            tick;
            clear_exp;
            case (vecs[n].k)
                1: x_b1[vecs[n].w] = 1'b1;
                2: x_b2[vecs[n].w] = 1'b1;
                3: x_b3[vecs[n].w] = 1'b1;
                4: x_b4[vecs[n].w] = 1'b1;
                5: x_b5[vecs[n].w] = 1'b1;
                6: x_b6[vecs[n].w] = 1'b1;
                7: x_b7[vecs[n].w] = 1'b1;
                default: x_b8[vecs[n].w] = 1'b1;
            endcase
            checks++;
            if ({b1, b2, b3, b4, b5, b6, b7, b8} !== {x_b1, x_b2, x_b3, x_b4, x_b5, x_b6, x_b7, x_b8}) begin
                failures++;
                $display("FAIL vec%0d_rows got=%h want=%h", n, {b1, b2, b3, b4, b5, b6, b7, b8},
                         {x_b1, x_b2, x_b3, x_b4, x_b5, x_b6, x_b7, x_b8});
            end
            checks++;
            if ({err1, err2} !== {vecs[n].e1, vecs[n].e2}) begin
                failures++;
                $display("FAIL vec%0d_err got=%b%b want=%b%b", n, err1, err2, vecs[n].e1, vecs[n].e2);
            end
        end
    endtask

    task automatic test_latency;
        set_all(16'h0000);
        tick;
        checks++;
        if ({b1, b2, b3, b4, b5, b6, b7, b8, err1, err2} !== 195'd0) begin
            failures++;
            $display("FAIL zero_in got=%h want=0", {b1, b2, b3, b4, b5, b6, b7, b8, err1, err2});
        end
        av[1] = 16'h0001;
        @(negedge clk);
        checks++;
        if (b1 !== 31'd0) begin
            failures++;
            $display("FAIL lat_before got=%h want=0", b1);
        end
        tick;
        checks++;
        if (b1 !== 31'd1) begin
            failures++;
            $display("FAIL lat_after got=%h want=1", b1);
        end
        av[1] = 16'h0000;
        tick;
        checks++;
        if (b1 !== 31'd0) begin
            failures++;
            $display("FAIL lat_clear got=%h want=0", b1);
        end
    endtask

    initial begin
        set_all(16'h0000);
        init_vecs;
        @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        test_all_ones("release");
        test_mid_reset;
        test_all_ones("ones");
        test_alternating;
        test_single_bits;
        test_latency;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
